// File: rtl/err_monitor.sv
// Watches the CPU commit stream and latches the first fault (illegal, misalign, stall, hang, commit-after-halt).
// Latency 1 cycle from sampled event to registered outputs; no backpressure, FAULT holds until reset.
module err_monitor #(
    parameter int PC_W        = 16,
    parameter int HANG_LIMIT  = 1000,
    parameter int STALL_LIMIT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            commit,
    input  logic [PC_W-1:0] commit_pc,
    input  logic            halt,
    input  logic            illegal_op,
    input  logic            misalign,
    input  logic            mem_stall,
    output logic            err,
    output logic [2:0]      err_code,
    output logic [PC_W-1:0] err_pc,
    output logic            halted,
    output logic [31:0]     commit_count
);

    localparam int HW = $clog2(HANG_LIMIT + 1);
    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [HW-1:0] HANG_LAST  = HW'(HANG_LIMIT - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [2:0] C_ILLEGAL  = 3'd1;
    localparam logic [2:0] C_MISALIGN = 3'd2;
    localparam logic [2:0] C_AFTER_HLT = 3'd3;
    localparam logic [2:0] C_STALL    = 3'd4;
    localparam logic [2:0] C_HANG     = 3'd5;

    logic [1:0]      state_q, state_d;
    logic            err_q, err_d;
    logic [2:0]      code_q, code_d;
    logic [PC_W-1:0] err_pc_q, err_pc_d;
    logic            halted_q, halted_d;
    logic [31:0]     count_q, count_d;
    logic [PC_W-1:0] last_pc_q, last_pc_d;
    logic [HW-1:0]   hang_q, hang_d;
    logic [SW-1:0]   stall_q, stall_d;

    logic stall_hit, hang_hit;

    // A watchdog fires on the cycle its counter would reach the limit, so compare against limit-1.
    assign stall_hit = mem_stall && (stall_q == STALL_LAST);
    assign hang_hit  = !commit && (hang_q == HANG_LAST);

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        code_d    = code_q;
        err_pc_d  = err_pc_q;
        halted_d  = halted_q;
        count_d   = count_q;
        last_pc_d = last_pc_q;
        hang_d    = hang_q;
        stall_d   = stall_q;
        case (state_q)
            ST_RUN: begin
                if (commit && illegal_op) begin
                    state_d = ST_FAULT; err_d = 1'b1; code_d = C_ILLEGAL; err_pc_d = commit_pc;
                end else if (commit && misalign) begin
                    state_d = ST_FAULT; err_d = 1'b1; code_d = C_MISALIGN; err_pc_d = commit_pc;
                end else if (stall_hit) begin
                    state_d = ST_FAULT; err_d = 1'b1; code_d = C_STALL; err_pc_d = last_pc_q;
                end else if (hang_hit) begin
                    state_d = ST_FAULT; err_d = 1'b1; code_d = C_HANG; err_pc_d = last_pc_q;
                end else begin
                    hang_d  = commit ? '0 : hang_q + 1'b1;
                    stall_d = mem_stall ? stall_q + 1'b1 : '0;
                    if (commit) begin
                        if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
                        last_pc_d = commit_pc;
                        if (halt) begin
                            state_d  = ST_HALT;
                            halted_d = 1'b1;
                        end
                    end
                end
            end
            ST_HALT: begin
                if (commit) begin
                    state_d = ST_FAULT; err_d = 1'b1; code_d = C_AFTER_HLT; err_pc_d = commit_pc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            err_q     <= 1'b0;
            code_q    <= 3'd0;
            err_pc_q  <= '0;
            halted_q  <= 1'b0;
            count_q   <= 32'd0;
            last_pc_q <= '0;
            hang_q    <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            code_q    <= code_d;
            err_pc_q  <= err_pc_d;
            halted_q  <= halted_d;
            count_q   <= count_d;
            last_pc_q <= last_pc_d;
            hang_q    <= hang_d;
            stall_q   <= stall_d;
        end
    end

    assign err          = err_q;
    assign err_code     = code_q;
    assign err_pc       = err_pc_q;
    assign halted       = halted_q;
    assign commit_count = count_q;

endmodule

// File: tb/tb_err_monitor.sv
// Bench for err_monitor with short watchdog limits: directed scenarios plus random traffic vs a rule-level model.
module tb_err_monitor;

    localparam int HANG  = 8;
    localparam int STALL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        commit = 1'b0;
    logic [15:0] commit_pc = '0;
    logic        halt = 1'b0, illegal_op = 1'b0, misalign = 1'b0, mem_stall = 1'b0;
    logic        err;
    logic [2:0]  err_code;
    logic [15:0] err_pc;
    logic        halted;
    logic [31:0] commit_count;

    int checks = 0;
    int errors = 0;

    err_monitor #(.PC_W(16), .HANG_LIMIT(HANG), .STALL_LIMIT(STALL)) dut (
        .clk(clk), .rst_n(rst_n), .commit(commit), .commit_pc(commit_pc),
        .halt(halt), .illegal_op(illegal_op), .misalign(misalign), .mem_stall(mem_stall),
        .err(err), .err_code(err_code), .err_pc(err_pc), .halted(halted),
        .commit_count(commit_count)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 running, 1 halted, 2 faulted.
    int          m_mode;
    bit          m_err, m_halted;
    int          m_code;
    int unsigned m_pc, m_last;
    longint      m_count;
    int          m_idle, m_stall;

    task automatic model_step(input bit r, input bit c, input int unsigned pc,
                              input bit h, input bit il, input bit ma, input bit st);
        int idle_n, stall_n, cause;
        if (!r) begin
            m_mode = 0; m_err = 0; m_halted = 0; m_code = 0; m_pc = 0; m_last = 0;
            m_count = 0; m_idle = 0; m_stall = 0;
            return;
        end
        if (m_mode == 2) return;
        if (m_mode == 1) begin
            if (c) begin m_mode = 2; m_err = 1; m_code = 3; m_pc = pc; end
            return;
        end
        idle_n  = c ? 0 : m_idle + 1;
        stall_n = st ? m_stall + 1 : 0;
        cause = 0;
        if (c && il) cause = 1;
        else if (c && ma) cause = 2;
        else if (stall_n >= STALL) cause = 4;
        else if (idle_n >= HANG) cause = 5;
        if (cause != 0) begin
            m_mode = 2; m_err = 1; m_code = cause;
            m_pc = (cause <= 2) ? pc : m_last;
            return;
        end
        m_idle = idle_n; m_stall = stall_n;
        if (c) begin
            if (m_count < 64'hFFFF_FFFF) m_count++;
            m_last = pc;
            if (h) begin m_mode = 1; m_halted = 1; end
        end
    endtask

    task automatic cyc(input bit r, input bit c, input int unsigned pc,
                       input bit h, input bit il, input bit ma, input bit st);
        @(negedge clk);
        rst_n = r; commit = c; commit_pc = pc[15:0]; halt = h;
        illegal_op = il; misalign = ma; mem_stall = st;
        @(posedge clk);
        model_step(r, c, pc & 32'hFFFF, h, il, ma, st);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        cyc(0, 1, 16'h55, 1, 1, 1, 1);
        checks += 5;
        if (err !== 1'b0)           begin errors++; $display("FAIL reset_err got %0b want 0", err); end
        if (err_code !== 3'd0)      begin errors++; $display("FAIL reset_code got %0d want 0", err_code); end
        if (err_pc !== 16'd0)       begin errors++; $display("FAIL reset_pc got %0d want 0", err_pc); end
        if (halted !== 1'b0)        begin errors++; $display("FAIL reset_halted got %0b want 0", halted); end
        if (commit_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", commit_count); end
    endtask

    task automatic test_clean_run;
        cyc(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 1, 2 * i, 0, 0, 0, 0);
        cyc(1, 1, 20, 1, 0, 0, 0);
        checks += 3;
        if (halted !== 1'b1)         begin errors++; $display("FAIL clean_halted got %0b want 1", halted); end
        if (commit_count !== 32'd11) begin errors++; $display("FAIL clean_count got %0d want 11", commit_count); end
        if (err !== 1'b0)            begin errors++; $display("FAIL clean_err got %0b want 0", err); end
        for (int i = 0; i < 2000; i++) cyc(1, 0, 0, 0, 0, 0, i % 3 != 0);
        checks += 2;
        if (err !== 1'b0)            begin errors++; $display("FAIL halt_idle_err got %0b want 0", err); end
        if (commit_count !== 32'd11) begin errors++; $display("FAIL halt_idle_count got %0d want 11", commit_count); end
    endtask

    task automatic test_illegal;
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 2, 0, 0, 0, 0);
        cyc(1, 1, 4, 0, 1, 1, 0);
        checks += 5;
        if (err !== 1'b1)           begin errors++; $display("FAIL ill_err got %0b want 1", err); end
        if (err_code !== 3'd1)      begin errors++; $display("FAIL ill_code got %0d want 1", err_code); end
        if (err_pc !== 16'd4)       begin errors++; $display("FAIL ill_pc got %0d want 4", err_pc); end
        if (commit_count !== 32'd2) begin errors++; $display("FAIL ill_count got %0d want 2", commit_count); end
        if (halted !== 1'b0)        begin errors++; $display("FAIL ill_halted got %0b want 0", halted); end
        cyc(1, 1, 8, 0, 0, 1, 0);
        cyc(1, 1, 10, 1, 0, 0, 1);
        checks += 4;
        if (err_code !== 3'd1)      begin errors++; $display("FAIL ill_hold_code got %0d want 1", err_code); end
        if (err_pc !== 16'd4)       begin errors++; $display("FAIL ill_hold_pc got %0d want 4", err_pc); end
        if (commit_count !== 32'd2) begin errors++; $display("FAIL ill_hold_count got %0d want 2", commit_count); end
        if (halted !== 1'b0)        begin errors++; $display("FAIL ill_hold_halted got %0b want 0", halted); end
    endtask

    task automatic test_hang;
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 4, 0, 0, 0, 0);
        idle(HANG - 1);
        cyc(1, 1, 6, 0, 0, 0, 0);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL hang_under_err got %0b want 0", err); end
        idle(HANG - 1);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL hang_early_err got %0b want 0", err); end
        idle(1);
        checks += 3;
        if (err !== 1'b1)      begin errors++; $display("FAIL hang_err got %0b want 1", err); end
        if (err_code !== 3'd5) begin errors++; $display("FAIL hang_code got %0d want 5", err_code); end
        if (err_pc !== 16'd6)  begin errors++; $display("FAIL hang_pc got %0d want 6", err_pc); end
    endtask

    task automatic test_stall;
        cyc(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < STALL - 1; i++) cyc(1, 1, 2 * i, 0, 0, 0, 1);
        cyc(1, 1, 40, 0, 0, 0, 0);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL stall_under_err got %0b want 0", err); end
        for (int i = 0; i < STALL - 1; i++) cyc(1, 0, 0, 0, 0, 0, 1);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL stall_early_err got %0b want 0", err); end
        cyc(1, 0, 0, 0, 0, 0, 1);
        checks += 3;
        if (err !== 1'b1)      begin errors++; $display("FAIL stall_err got %0b want 1", err); end
        if (err_code !== 3'd4) begin errors++; $display("FAIL stall_code got %0d want 4", err_code); end
        if (err_pc !== 16'd40) begin errors++; $display("FAIL stall_pc got %0d want 40", err_pc); end
    endtask

    task automatic test_commit_after_halt;
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 10, 1, 0, 0, 0);
        cyc(1, 1, 12, 0, 0, 0, 0);
        checks += 4;
        if (err_code !== 3'd3)      begin errors++; $display("FAIL cah_code got %0d want 3", err_code); end
        if (err_pc !== 16'd12)      begin errors++; $display("FAIL cah_pc got %0d want 12", err_pc); end
        if (halted !== 1'b1)        begin errors++; $display("FAIL cah_halted got %0b want 1", halted); end
        if (commit_count !== 32'd1) begin errors++; $display("FAIL cah_count got %0d want 1", commit_count); end
    endtask

    task automatic test_reset_mid_fault;
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 2, 0, 0, 0, 0);
        cyc(1, 1, 7, 0, 0, 1, 0);
        checks += 2;
        if (err_code !== 3'd2) begin errors++; $display("FAIL rmf_code got %0d want 2", err_code); end
        if (err_pc !== 16'd7)  begin errors++; $display("FAIL rmf_pc got %0d want 7", err_pc); end
        cyc(0, 1, 9, 0, 1, 0, 1);
        checks += 4;
        if (err !== 1'b0)           begin errors++; $display("FAIL rmf_err got %0b want 0", err); end
        if (err_code !== 3'd0)      begin errors++; $display("FAIL rmf_code0 got %0d want 0", err_code); end
        if (err_pc !== 16'd0)       begin errors++; $display("FAIL rmf_pc0 got %0d want 0", err_pc); end
        if (commit_count !== 32'd0) begin errors++; $display("FAIL rmf_count0 got %0d want 0", commit_count); end
        cyc(1, 1, 30, 0, 0, 0, 0);
        checks += 2;
        if (commit_count !== 32'd1) begin errors++; $display("FAIL rmf_count1 got %0d want 1", commit_count); end
        if (err !== 1'b0)           begin errors++; $display("FAIL rmf_err1 got %0b want 0", err); end
    endtask

    task automatic test_random;
        for (int seg = 0; seg < 12; seg++) begin
            int c_pct, s_pct;
            c_pct = 20 + 7 * seg;
            s_pct = (seg % 3) * 25;
            cyc(0, 0, 0, 0, 0, 0, 0);
            for (int i = 0; i < 250; i++) begin
                bit r, c, h, il, ma, st;
                r  = ($urandom_range(199) != 0);
                c  = ($urandom_range(99) < c_pct);
                h  = ($urandom_range(99) < 3);
                il = ($urandom_range(99) < 2);
                ma = ($urandom_range(99) < 2);
                st = ($urandom_range(99) < s_pct);
                cyc(r, c, $urandom_range(16'hFFFF), h, il, ma, st);
                checks++;
                if (err !== m_err || err_code !== 3'(m_code) || err_pc !== 16'(m_pc) ||
                    halted !== m_halted || commit_count !== 32'(m_count)) begin
                    errors++;
                    $display("FAIL random seg%0d cyc%0d got err=%0b code=%0d pc=%0h halted=%0b cnt=%0d want err=%0b code=%0d pc=%0h halted=%0b cnt=%0d",
                             seg, i, err, err_code, err_pc, halted, commit_count,
                             m_err, m_code, m_pc, m_halted, m_count);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_clean_run;
        test_illegal;
        test_hang;
        test_stall;
        test_commit_after_halt;
        test_reset_mid_fault;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
